// File: rtl/mac_pe.sv
// Weight-stationary signed multiply-accumulate PE for the systolic array.
// Define MAC_PE_SATURATE_EN to saturate the accumulate add instead of wrapping.
module mac_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load_weight,
   input  logic                  clear_acc,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic [DATA_WIDTH-1:0] act_in,
   output logic [DATA_WIDTH-1:0] act_out,
   input  logic [ACC_WIDTH-1:0]  psum_in,
   output logic [ACC_WIDTH-1:0]  psum_out
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] weight_reg;
   logic signed [PROD_WIDTH-1:0] product;
   logic signed [ACC_WIDTH-1:0]  product_ext;
   logic        [ACC_WIDTH-1:0]  sum_next;

   assign product     = weight_reg * $signed(act_in);
   assign product_ext = {{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product};

`ifdef MAC_PE_SATURATE_EN
   // One guard bit exposes signed overflow: the top two bits disagree.
   logic [ACC_WIDTH:0] sum_wide;

   assign sum_wide = {psum_in[ACC_WIDTH-1], psum_in} +
                     {product_ext[ACC_WIDTH-1], product_ext};

   always_comb begin
      sum_next = sum_wide[ACC_WIDTH-1:0];
      if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
         if (sum_wide[ACC_WIDTH])
            sum_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         else
            sum_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_next = psum_in + product_ext;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         weight_reg <= '0;
      else if (load_weight)
         weight_reg <= weight_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_out  <= '0;
         psum_out <= '0;
      end else if (enable) begin
         act_out  <= act_in;
         psum_out <= clear_acc ? '0 : sum_next;
      end
   end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: directed cases plus randomized traffic against an arithmetic model.
module tb_mac_pe;

   localparam int DW = 8;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable, load_weight, clear_acc;
   logic [DW-1:0] weight_in, act_in, act_out;
   logic [AW-1:0] psum_in, psum_out;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference state
   logic [DW-1:0] m_weight, m_act;
   logic [AW-1:0] m_psum;

   mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load_weight(load_weight),
      .clear_acc(clear_acc), .weight_in(weight_in), .act_in(act_in),
      .act_out(act_out), .psum_in(psum_in), .psum_out(psum_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] model_sum(input logic [AW-1:0] p, input logic [DW-1:0] w,
                                               input logic [DW-1:0] a);
      longint s;
      s = longint'($signed(p)) + longint'($signed(w)) * longint'($signed(a));
`ifdef MAC_PE_SATURATE_EN
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
      return s[AW-1:0];
   endfunction

   // Drive one cycle, advance the model at the edge, then compare just after it.
   task automatic cycle(input string tag, input logic en, input logic lw, input logic clr,
                        input logic [DW-1:0] w, input logic [DW-1:0] a, input logic [AW-1:0] p);
      enable = en; load_weight = lw; clear_acc = clr;
      weight_in = w; act_in = a; psum_in = p;
      @(posedge clk);
      if (en) begin
         m_act  = a;
         m_psum = clr ? '0 : model_sum(p, m_weight, a);
      end
      if (lw) m_weight = w;
      #1;
      check({tag, ".act"}, AW'(act_out), AW'(m_act));
      check({tag, ".psum"}, psum_out, m_psum);
   endtask

   task automatic model_reset();
      m_weight = '0; m_act = '0; m_psum = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 0; load_weight = 0; clear_acc = 0;
      weight_in = '0; act_in = '0; psum_in = '0;
      model_reset();
      #3;
      check("reset_async.psum", psum_out, '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset.act", AW'(act_out), '0);
      check("reset.psum", psum_out, '0);
      @(negedge clk) rst_n = 1'b1;

      // Weight load alone leaves outputs untouched
      cycle("load3", 0, 1, 0, 8'd3, 8'd9, 32'd100);
      cycle("clear", 1, 0, 1, 8'd0, 8'd4, 32'd0);
      check("clear.psum_zero", psum_out, 32'd0);
      cycle("mac12", 1, 0, 0, 8'd0, 8'd4, 32'd0);
      check("mac12.psum_exact", psum_out, 32'd12);
      check("mac12.act_exact", AW'(act_out), 32'd4);
      // No self-accumulation: same inputs twice give the same result
      cycle("noself1", 1, 0, 0, 8'd0, 8'd5, 32'd12);
      cycle("noself2", 1, 0, 0, 8'd0, 8'd5, 32'd12);
      check("noself.psum_exact", psum_out, 32'd27);
      cycle("clr2", 1, 0, 1, 8'd0, 8'd1, 32'd55);
      cycle("neg", 1, 0, 0, 8'd0, 8'hFE, 32'd0);
      check("neg.psum_exact", psum_out, 32'hFFFF_FFFA);
      // Load in the same cycle as a MAC: old weight (3) used, new one next cycle
      cycle("ld127_old", 1, 1, 0, 8'd127, 8'd127, 32'd0);
      check("ld127_old.psum_exact", psum_out, 32'd381);
      cycle("ld127_new", 1, 0, 0, 8'd0, 8'd127, 32'd0);
      check("ld127_new.psum_exact", psum_out, 32'd16129);
      cycle("ldm5", 0, 1, 0, 8'hFB, 8'd0, 32'd0);
      cycle("negneg", 1, 0, 0, 8'd0, 8'hF9, 32'd0);
      check("negneg.psum_exact", psum_out, 32'd35);
      // enable=0 holds even with clear asserted and inputs changed
      cycle("hold", 0, 0, 1, 8'd0, 8'h55, 32'h1234_5678);
      check("hold.psum_exact", psum_out, 32'd35);
      check("hold.act_exact", AW'(act_out), 32'hF9);
      cycle("ld1", 0, 1, 0, 8'd1, 8'd0, 32'd0);
      cycle("ovf", 1, 0, 0, 8'd0, 8'd1, 32'h7FFF_FFFF);
`ifdef MAC_PE_SATURATE_EN
      check("ovf.psum_exact", psum_out, 32'h7FFF_FFFF);
`else
      check("ovf.psum_exact", psum_out, 32'h8000_0000);
`endif
      cycle("ldmax", 0, 1, 0, 8'h80, 8'd0, 32'd0);
      cycle("novf", 1, 0, 0, 8'd0, 8'h7F, 32'h8000_0000);

      // Randomized traffic with occasional extreme partial sums
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] p;
         case ($urandom_range(0, 5))
            0:       p = 32'h7FFF_FFF0 + AW'($urandom_range(0, 15));
            1:       p = 32'h8000_0000 + AW'($urandom_range(0, 15));
            default: p = $urandom;
         endcase
         cycle("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 6) == 0), DW'($urandom), DW'($urandom), p);
      end

      // Reset mid-operation clears outputs immediately and holds them
      enable = 1; load_weight = 1; clear_acc = 0;
      weight_in = 8'd7; act_in = 8'd9; psum_in = 32'd1000;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst.act", AW'(act_out), '0);
      check("midrst.psum", psum_out, '0);
      @(posedge clk);
      #1;
      check("midrst_hold.psum", psum_out, '0);
      @(negedge clk) rst_n = 1'b1;
      // Weight was cleared by reset, so product is 0
      cycle("postrst", 1, 0, 0, 8'd0, 8'd9, 32'd1000);
      check("postrst.psum_exact", psum_out, 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
